// File: rtl/hex_word_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the hex word loader: FSM state encoding,
// word/nibble geometry and the nibble shift helper used to assemble words.
// No ports (package).
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int unsigned WORD_W           = 16;
  localparam int unsigned NIB_W            = 4;
  localparam int unsigned NIBBLES_PER_WORD = 4;
  localparam int unsigned IDX_W            = 2;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    WRITE   = 1'b1
  } state_e;

  // Shift a nibble into the low end so the first nibble entered ends up MSB.
  function automatic logic [WORD_W-1:0] shift_in_nibble(
    input logic [WORD_W-1:0] word,
    input logic [NIB_W-1:0]  nib
  );
    return {word[WORD_W-NIB_W-1:0], nib};
  endfunction

endpackage

// File: rtl/hex_word_loader_if.sv
// ---------------------------------------------------------------------------
// hex_word_loader_if
// Valid/ready memory write port between the loader and program memory.
//   wr_valid : loader -> memory, write request
//   wr_ready : memory -> loader, write accepted when high with wr_valid
//   wr_addr  : loader -> memory, 16-bit write address
//   wr_data  : loader -> memory, 16-bit write data
// Modports: master (loader side), slave (memory side).
// ---------------------------------------------------------------------------
interface hex_word_loader_if;
  import loader_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/hex_word_loader_key_pulse.sv
// ---------------------------------------------------------------------------
// key_pulse
// Turns the raw, active-low, asynchronous Enter button into a single-cycle
// press pulse: 2-flop synchronizer -> optional debounce -> press-edge detect.
// Release never produces a pulse.
// Optional feature macro: LOADER_DEBOUNCE_EN (debounce counter between the
// synchronizer and the edge detector; DEBOUNCE_CYCLES ignored otherwise).
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   key_n       : raw Enter button, active-low, asynchronous
//   enter_pulse : one-cycle pulse on each accepted press
// ---------------------------------------------------------------------------
module key_pulse #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic enter_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_pulse: DEBOUNCE_CYCLES must be at least 1");
  end

  // Synchronizer flops hold the raw (active-low) level; reset to released.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic pressed_s;
  logic level_s;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // Synchronizer next state: shift the raw key through two flops.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  assign pressed_s = ~sync2_q;

`ifdef LOADER_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce: flip the accepted level only after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles; any agreeing cycle (bounce) restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (pressed_s != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = pressed_s;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_s = level_q;
`else
  assign level_s = pressed_s;
`endif

  // Edge detector next state: pulse only on released -> pressed.
  always_comb begin
    prev_d  = level_s;
    pulse_d = level_s & ~prev_q;
  end

  // Synchronizer and edge-detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign enter_pulse = pulse_q;

endmodule

// File: rtl/hex_word_loader.sv
// ---------------------------------------------------------------------------
// hex_word_loader
// Operator-driven memory loader. Assembles 16-bit words one hex nibble at a
// time (switches + Enter), then writes each completed word to program memory
// at an auto-incrementing address over a valid/ready port.
// Optional feature macro: LOADER_DEBOUNCE_EN (Enter key debounce).
// Parameters:
//   BASE_ADDR       : address of the first write after reset
//   DEBOUNCE_CYCLES : stable cycles to accept a key change (>=1, debounce only)
// Ports:
//   Clock     : system clock, all state on posedge
//   Reset     : synchronous active-high reset
//   SW_NIB    : nibble from the switches, sampled on the Enter pulse
//   KEY_ENTER : raw Enter button, active-low, asynchronous
//   wr        : memory write port (master modport)
//   word_out  : word being assembled (display)
//   addr_out  : next write address (display)
//   nib_idx   : nibbles entered into the current word (0-3)
// ---------------------------------------------------------------------------
module hex_word_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NIB_W-1:0]        SW_NIB,
  input  logic                    KEY_ENTER,
  hex_word_loader_if.master       wr,
  output logic [WORD_W-1:0]       word_out,
  output logic [WORD_W-1:0]       addr_out,
  output logic [IDX_W-1:0]        nib_idx
);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NIBBLES_PER_WORD - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
  localparam logic [WORD_W-1:0] WORD_ZERO = WORD_W'(0);
  localparam logic [WORD_W-1:0] ADDR_ONE  = WORD_W'(1);

  logic enter_pulse_s;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  nib_q, nib_d;
  logic              wr_valid_q, wr_valid_d;
  logic [WORD_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [WORD_W-1:0] addr_q, addr_d;

  key_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_pulse (
    .clk         (Clock),
    .rst         (Reset),
    .key_n       (KEY_ENTER),
    .enter_pulse (enter_pulse_s)
  );

  // FSM next state and datapath: collect nibbles, then hold the write
  // request until the memory accepts it. Enter presses in WRITE are dropped.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nib_d      = nib_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    addr_d     = addr_q;
    case (state_q)
      COLLECT: begin
        if (enter_pulse_s) begin
          word_d = shift_in_nibble(word_q, SW_NIB);
          if (nib_q == LAST_IDX) begin
            nib_d      = IDX_ZERO;
            wr_data_d  = shift_in_nibble(word_q, SW_NIB);
            wr_addr_d  = addr_q;
            wr_valid_d = 1'b1;
            state_d    = WRITE;
          end else begin
            nib_d = nib_q + IDX_ONE;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      WRITE: begin
        if (wr_valid_q && wr.wr_ready) begin
          wr_valid_d = 1'b0;
          addr_d     = addr_q + ADDR_ONE;  // wraps modulo 2^16
          state_d    = COLLECT;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d    = COLLECT;
        wr_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any pending write.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= COLLECT;
      word_q     <= WORD_ZERO;
      nib_q      <= IDX_ZERO;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= WORD_ZERO;
      wr_data_q  <= WORD_ZERO;
      addr_q     <= BASE_ADDR;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nib_q      <= nib_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_q     <= addr_d;
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign word_out    = word_q;
  assign addr_out    = addr_q;
  assign nib_idx     = nib_q;

endmodule

// File: tb/tb_hex_word_loader.sv
// ---------------------------------------------------------------------------
// tb_hex_word_loader
// Directed bench for hex_word_loader. Two instances: A with BASE_ADDR 0x0100
// and B with BASE_ADDR 0xFFFF. Expected writes are queued when stimulus is
// issued; a monitor pops and compares on every handshake and checks that a
// stalled request stays stable.
// ---------------------------------------------------------------------------
module tb_hex_word_loader;
  import loader_pkg::*;

`ifdef LOADER_DEBOUNCE_EN
  localparam int HOLD = 16;
`else
  localparam int HOLD = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        key_a, key_b;
  logic [3:0]  sw;
  logic [15:0] word_a, word_b, addr_a, addr_b;
  logic [1:0]  nib_a, nib_b;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  logic        prev_v [2];
  logic        prev_hs[2];
  logic        prev_r [2];
  logic [15:0] prev_ad[2];
  logic [15:0] prev_dt[2];

  hex_word_loader_if if_a();
  hex_word_loader_if if_b();

  always #5 clk = ~clk;

  hex_word_loader #(.BASE_ADDR(16'h0100), .DEBOUNCE_CYCLES(8)) dut_a (
    .Clock(clk), .Reset(rst_a), .SW_NIB(sw), .KEY_ENTER(key_a), .wr(if_a),
    .word_out(word_a), .addr_out(addr_a), .nib_idx(nib_a));

  hex_word_loader #(.BASE_ADDR(16'hFFFF), .DEBOUNCE_CYCLES(8)) dut_b (
    .Clock(clk), .Reset(rst_b), .SW_NIB(sw), .KEY_ENTER(key_b), .wr(if_b),
    .word_out(word_b), .addr_out(addr_b), .nib_idx(nib_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input logic [3:0] nib);
    sw = nib;
    if (which == 0) key_a = 1'b0; else key_b = 1'b0;
    cyc(HOLD);
    if (which == 0) key_a = 1'b1; else key_b = 1'b1;
    cyc(HOLD);
  endtask

  task automatic key_level(input logic lvl, input int n);
    key_a = lvl;
    cyc(n);
  endtask

  // Per-port monitor: scoreboard pop on handshake, stability while stalled.
  task automatic mon(input int which, input logic v, input logic r, input logic rs,
                     input logic [15:0] ad, input logic [15:0] dt);
    logic [31:0] e;
    logic hs;
    hs = v && r && !rs;
    if (hs) begin
      if (which == 0 && exp_a.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write_a: got addr %h data %h expected none", ad, dt);
      end else if (which == 1 && exp_b.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write_b: got addr %h data %h expected none", ad, dt);
      end else begin
        e = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
        check($sformatf("wr_addr_%0d", which), {16'h0000, ad}, {16'h0000, e[31:16]});
        check($sformatf("wr_data_%0d", which), {16'h0000, dt}, {16'h0000, e[15:0]});
      end
    end
    if (prev_v[which] && !prev_hs[which] && !prev_r[which] && !rs) begin
      check($sformatf("stall_valid_%0d", which), {31'd0, v}, 32'd1);
      check($sformatf("stall_addr_%0d", which), {16'h0000, ad}, {16'h0000, prev_ad[which]});
      check($sformatf("stall_data_%0d", which), {16'h0000, dt}, {16'h0000, prev_dt[which]});
    end
    prev_v[which]  = v;
    prev_hs[which] = hs;
    prev_r[which]  = rs;
    prev_ad[which] = ad;
    prev_dt[which] = dt;
  endtask

  // Monitor process, decoupled from stimulus.
  always @(negedge clk) begin
    mon(0, if_a.wr_valid, if_a.wr_ready, rst_a, if_a.wr_addr, if_a.wr_data);
    mon(1, if_b.wr_valid, if_b.wr_ready, rst_b, if_b.wr_addr, if_b.wr_data);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_v[i] = 1'b0; prev_hs[i] = 1'b0; prev_r[i] = 1'b1;
      prev_ad[i] = 16'h0000; prev_dt[i] = 16'h0000;
    end
    rst_a = 1'b1; rst_b = 1'b1; key_a = 1'b1; key_b = 1'b1; sw = 4'h0;
    if_a.wr_ready = 1'b0; if_b.wr_ready = 1'b0;

    // Reset values
    cyc(2);
    @(negedge clk);
    check("rst_valid_a", {31'd0, if_a.wr_valid}, 32'd0);
    check("rst_addr_out_a", {16'h0000, addr_a}, 32'h0000_0100);
    check("rst_word_a", {16'h0000, word_a}, 32'h0);
    check("rst_nib_a", {30'd0, nib_a}, 32'd0);
    check("rst_wr_addr_a", {16'h0000, if_a.wr_addr}, 32'h0);
    check("rst_wr_data_a", {16'h0000, if_a.wr_data}, 32'h0);
    check("rst_addr_out_b", {16'h0000, addr_b}, 32'h0000_FFFF);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    cyc(2);

    // Word entry with ready already high
    if_a.wr_ready = 1'b1;
    exp_a.push_back({16'h0100, 16'hABCD});
    press(0, 4'hA); check("nib_after_1", {30'd0, nib_a}, 32'd1);
    press(0, 4'hB); check("nib_after_2", {30'd0, nib_a}, 32'd2);
    press(0, 4'hC); check("nib_after_3", {30'd0, nib_a}, 32'd3);
    check("word_partial", {16'h0000, word_a}, 32'h0000_0ABC);
    press(0, 4'hD); check("nib_after_4", {30'd0, nib_a}, 32'd0);
    check("word_full", {16'h0000, word_a}, 32'h0000_ABCD);
    check("addr_after_write", {16'h0000, addr_a}, 32'h0000_0101);
    check("valid_after_write", {31'd0, if_a.wr_valid}, 32'd0);
    check("queue_a_empty_1", exp_a.size(), 32'd0);

    // Backpressure with ignored presses
    if_a.wr_ready = 1'b0;
    exp_a.push_back({16'h0101, 16'h1234});
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3); press(0, 4'h4);
    check("bp_valid", {31'd0, if_a.wr_valid}, 32'd1);
    check("bp_wr_addr", {16'h0000, if_a.wr_addr}, 32'h0000_0101);
    check("bp_wr_data", {16'h0000, if_a.wr_data}, 32'h0000_1234);
    press(0, 4'h5); press(0, 4'h6);
    check("bp_word_held", {16'h0000, word_a}, 32'h0000_1234);
    check("bp_nib_held", {30'd0, nib_a}, 32'd0);
    check("bp_still_valid", {31'd0, if_a.wr_valid}, 32'd1);
    check("bp_addr_held", {16'h0000, addr_a}, 32'h0000_0101);
    if_a.wr_ready = 1'b1;
    cyc(3);
    check("bp_done_valid", {31'd0, if_a.wr_valid}, 32'd0);
    check("bp_done_addr", {16'h0000, addr_a}, 32'h0000_0102);
    check("queue_a_empty_2", exp_a.size(), 32'd0);

    // Address wrap on B
    if_b.wr_ready = 1'b1;
    exp_b.push_back({16'hFFFF, 16'h1234});
    exp_b.push_back({16'h0000, 16'h5678});
    press(1, 4'h1); press(1, 4'h2); press(1, 4'h3); press(1, 4'h4);
    check("wrap_addr_mid", {16'h0000, addr_b}, 32'h0000_0000);
    press(1, 4'h5); press(1, 4'h6); press(1, 4'h7); press(1, 4'h8);
    check("wrap_addr_end", {16'h0000, addr_b}, 32'h0000_0001);
    check("wrap_word_b", {16'h0000, word_b}, 32'h0000_5678);
    check("queue_b_empty", exp_b.size(), 32'd0);

    // Reset while a write is stalled: no handshake must follow
    if_a.wr_ready = 1'b0;
    press(0, 4'h9); press(0, 4'h8); press(0, 4'h7); press(0, 4'h6);
    check("mid_valid_before", {31'd0, if_a.wr_valid}, 32'd1);
    check("mid_wr_data_before", {16'h0000, if_a.wr_data}, 32'h0000_9876);
    rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid_after", {31'd0, if_a.wr_valid}, 32'd0);
    check("mid_addr_after", {16'h0000, addr_a}, 32'h0000_0100);
    check("mid_nib_after", {30'd0, nib_a}, 32'd0);
    check("mid_word_after", {16'h0000, word_a}, 32'h0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    if_a.wr_ready = 1'b1;
    cyc(6);
    check("mid_no_write_addr", {16'h0000, addr_a}, 32'h0000_0100);

`ifdef LOADER_DEBOUNCE_EN
    // Debounce: bounces then a solid press gives exactly one nibble
    sw = 4'h5;
    for (int k = 0; k < 3; k++) begin
      key_level(1'b0, 3);
      key_level(1'b1, 3);
    end
    key_level(1'b0, 12);
    key_level(1'b1, 16);
    check("deb_nib", {30'd0, nib_a}, 32'd1);
    check("deb_word", {16'h0000, word_a}, 32'h0000_0005);
    // A 7-cycle glitch is shorter than the debounce window
    sw = 4'h9;
    key_level(1'b0, 7);
    key_level(1'b1, 16);
    check("glitch_nib", {30'd0, nib_a}, 32'd1);
    check("glitch_word", {16'h0000, word_a}, 32'h0000_0005);
`else
    // Without debounce a short press still registers exactly once
    sw = 4'h5;
    key_level(1'b0, 4);
    key_level(1'b1, 6);
    check("short_nib", {30'd0, nib_a}, 32'd1);
    check("short_word", {16'h0000, word_a}, 32'h0000_0005);
`endif

    cyc(2);
    check("final_queue_a", exp_a.size(), 32'd0);
    check("final_queue_b", exp_b.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_word_loader.md
# hex_word_loader

Operator-driven memory loader: assembles 16-bit words one hex nibble at a time from four slide switches and an Enter push-button, then writes each completed word into program memory at an auto-incrementing address through a valid/ready write port. It sits between the board switches/keys and the memory write port. Its `word_out`/`addr_out` feed the existing 7-segment hex display path, so the operator sees what is being entered.

## Interface
- `BASE_ADDR`, 16'h0000: address of the first write after reset.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a key level change; must be ≥1. Used only with debounce compiled in.
- `Clock`  in  1  system clock; all state on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `SW_NIB`  in  4  nibble value from the switches; sampled on the Enter pulse.
- `KEY_ENTER`  in  1  raw Enter button, active-low, asynchronous to `Clock`.
- `wr_valid`  out  1  write request.
- `wr_ready`  in  1  memory accepts the write when high together with `wr_valid`.
- `wr_addr`  out  16  write address.
- `wr_data`  out  16  write data.
- `word_out`  out  16  word being assembled, for the hex display.
- `addr_out`  out  16  next write address, for the hex display.
- `nib_idx`  out  2  count of nibbles entered into the current word (0–3).

## Operation
- **Key path:** `KEY_ENTER` passes through a 2-flop synchronizer, is inverted to active-high, and is turned into a one-cycle `enter_pulse` on the press (released→pressed) edge only. Release never generates a pulse.
- **FSM states:**
  - `COLLECT`: entry state.
  - `WRITE`.
- **In `COLLECT`, on `enter_pulse`:**
  - `word_out <= {word_out[11:0], SW_NIB}`, so the first nibble entered ends up most significant.
  - If `nib_idx == 3`: `nib_idx <= 0`, `wr_data <= {word_out[11:0], SW_NIB}`, `wr_addr <= addr_out`, `wr_valid <= 1`, state goes to `WRITE`.
  - Otherwise `nib_idx <= nib_idx + 1`.
- **In `WRITE`:**
  - `wr_valid`, `wr_addr` and `wr_data` are held stable until an edge where `wr_valid && wr_ready`.
  - On that edge: `wr_valid <= 0`, `addr_out <= addr_out + 1` (modulo 2^16, so 16'hFFFF wraps to 16'h0000), state returns to `COLLECT`.
  - `enter_pulse` arriving in `WRITE` is dropped: no shift and no count change.
- **Simultaneous events:** if `wr_ready` is already high on the first `WRITE` cycle, the write completes on that edge.
- **Reset:** reset mid-write aborts the write; no partial write and no address increment. Reset takes priority over all other events.
- **Reset values:**
  - `word_out`, `wr_data`, `wr_addr`, `nib_idx` = 0.
  - `wr_valid` = 0.
  - `addr_out` = `BASE_ADDR`.
  - state = `COLLECT`.
  - synchronizer and debounce state = released.

## Timing
- **Without debounce:** `enter_pulse` is high for exactly one cycle, on the 3rd rising edge after the first edge that samples `KEY_ENTER` low. `word_out` updates on the following edge.
- **With debounce:** the debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count. `enter_pulse` fires one cycle after the debounced level goes pressed.
- **4th nibble:** `wr_valid` rises on the same edge that shifts in the 4th nibble.
- **Write throughput:** at most one write per completed word. Minimum `wr_valid` high time is 1 cycle.

## Configuration
- `LOADER_DEBOUNCE_EN`:
  - Defined: the debounce counter (`$clog2(DEBOUNCE_CYCLES+1)` bits) is instantiated between the synchronizer and the edge detector.
  - Undefined: the synchronizer output drives the edge detector directly, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- **`loader_pkg`:**
  - FSM state enum (`COLLECT`, `WRITE`).
  - `NIBBLES_PER_WORD = 4`.
  - Word/address width constant (16).
- **Sub-module `key_pulse`:** synchronizer, optional debounce, and press-edge detector; outputs `enter_pulse`. The debounce is under `LOADER_DEBOUNCE_EN` inside it.

## Test plan
- **Reset value:** assert `Reset` for 2 cycles with `BASE_ADDR`=16'h0100 → all outputs at reset values, `addr_out`=16'h0100.
- **Word entry:** enter nibbles A,B,C,D with `wr_ready`=1 → one write, `wr_addr`=16'h0100, `wr_data`=16'hABCD; `addr_out`=16'h0101; `word_out`=16'hABCD.
- **Backpressure:** hold `wr_ready`=0 for 10 cycles after the 4th nibble and press Enter twice meanwhile → `wr_valid`, address and data stable throughout; presses ignored (`word_out`, `nib_idx` unchanged); the write completes when `wr_ready` goes 1.
- **Address wrap:** `BASE_ADDR`=16'hFFFF, write 16'h1234 then 16'h5678 → writes at 16'hFFFF and 16'h0000.
- **Reset mid-write:** assert `Reset` while `wr_valid`=1 and `wr_ready`=0 → `wr_valid`=0 next cycle, `addr_out`=`BASE_ADDR`, and no handshake occurs.
- **Debounce** (with `LOADER_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=8): press with 3-cycle bounces, then hold low for 8 cycles → exactly one `enter_pulse`, and `nib_idx` goes 0→1. A 7-cycle glitch produces no pulse.
